alu_pipelined_flags: RTL
========================

// Module: alu_pipelined_flags
// PURPOSE
//  Registered, parametrised successor of the combinational ALU: same 5-bit opcode map, any WIDTH.
//  Adds a valid/ready handshake, an output register and an architectural NZCV flag register.
//  ADC/SBC/RSC take carry from the stored C flag, so multiword arithmetic chains with no external Cin.
//  Sits between operand fetch and register-file writeback in the datapath.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; minimum 8.
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high; clears all state
//  in_valid      in   1      operation offered
//  in_ready      out  1      operation accepted when in_valid & in_ready at the clk edge
//  in_a          in   WIDTH  operand A
//  in_b          in   WIDTH  operand B
//  in_op         in   5      opcode (see BEHAVIOUR)
//  in_set_flags  in   1      1 = this op may update NZCV
//  out_valid     out  1      result register holds a valid result
//  out_ready     in   1      consumer takes the result when out_valid & out_ready at the edge
//  out_data      out  WIDTH  result
//  out_wr        out  1      1 = result is to be written back; 0 for TST/TEQ/CMP/CMN and for errors
//  out_err       out  1      1 = undefined opcode
//  flags         out  4      {N,Z,C,V} architectural flag register
// BEHAVIOUR
//  Reset: in_ready=0 while reset is high. out_valid=0, out_data=0, out_wr=0, out_err=0, flags=4'b0000, FSM=IDLE.
//  Handshake: in_ready = (state==IDLE) & (~out_valid | out_ready); latency 1 (accept at edge k -> out_valid after edge k).
//  Full throughput: one op per cycle while out_ready=1. A stalled result register holds out_* stable.
//  Opcodes: 00 AND, 01 EOR, 02 SUB A-B, 03 RSB B-A, 04 ADD, 05 ADC A+B+C, 06 SBC A-B-~C, 07 RSC B-A-~C,
//   08 TST (AND), 09 TEQ (EOR), 0A CMP (SUB), 0B CMN (ADD), 0C ORR, 0D MOV B, 0E BIC A&~B, 0F MVN ~B,
//   10 PASS A, 11 A+4, 12 A+B+4, 13-1F undefined.
//  Arithmetic: computed WIDTH+1 bits wide; carry = bit WIDTH.
//  Subtract-class C: C = NOT borrow, so 5-5 gives C=1.
//  V (add-class): A[W-1]==B'[W-1] and result[W-1]!=A[W-1], where B' is the effective addend (~B for subtract).
//  Flag update happens at the accept edge, only when in_set_flags=1 and the opcode is 00-0F:
//   - N = res[W-1]; Z = (res==0).
//   - C,V are updated by arithmetic ops (02-07, 0A, 0B) only; logical ops leave C,V unchanged.
//   - Ops 10-12 never update flags.
//  TST/TEQ/CMP/CMN: out_data = computed value, out_wr=0.
//  Undefined opcode: out_data=0, out_wr=0, out_err=1, flags unchanged.
//  Carry for op k+1 is the flag value after op k; back-to-back ADC chains need no bubble.
//  Reset asserted mid-operation: everything returns to reset values immediately; an in-flight op is lost.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - Opcode 13 = MUL: low WIDTH bits of A*B, computed by an iterative shift-add, one bit per cycle.
//   - FSM IDLE->MUL_BUSY on accept (in_ready=0 while busy); MUL_BUSY->IDLE after WIDTH cycles.
//   - Result is loaded, out_valid=1, out_wr=1 exactly WIDTH cycles after the accept edge.
//   - If out_valid is still held from a prior op when MUL finishes, FSM waits in MUL_BUSY until the register frees.
//   - Flags: N,Z update if in_set_flags=1, applied at result load; C,V unchanged.
//  ALU_MUL_EN undefined: opcode 13 is undefined (out_err=1), FSM never leaves IDLE, no multiplier logic.
// TESTING (WIDTH=32)
//  1. ADD FFFFFFFF+00000001, S=1 -> out 00000000, flags N0 Z1 C1 V0, out_wr=1, one cycle after accept.
//  2. SUB 80000000-00000001, S=1 -> 7FFFFFFF, N0 Z0 C1 V1; then CMP 5,5 -> out_wr=0, Z1 C1, out_data 0.
//  3. 64-bit chain: ADD FFFFFFFF+1 S=1, then ADC 0+0 back-to-back -> second result 00000001.
//  4. out_ready=0 for 3 cycles with a second op pending -> in_ready=0, out_data/flags stable, no op lost.
//  5. Op 1F, S=1 -> out_err=1, out_data 0, out_wr=0, flags unchanged; reset mid-stream clears flags/out_valid asynchronously.
//  6. With ALU_MUL_EN: MUL 7*6 S=1 -> 0000002A after 32 cycles, Z0 N0; reset at cycle 10 -> FSM IDLE, in_ready=1 after deassert.

Source files
------------

// File: rtl/alu_pipelined_flags.sv
// Registered ALU with valid/ready handshake, output register and NZCV flag register.
// Define ALU_MUL_EN to add opcode 13 (iterative shift-add MUL); otherwise 13 is undefined.
module alu_pipelined_flags #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_op,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wr,
    output logic             out_err,
    output logic [3:0]       flags,
    output logic             dbg_state
);

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_wr_q;
    logic             out_err_q;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the result register frees when it is empty or being drained in the same cycle.
    logic out_free;
    logic accept;
    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = ~reset & (state_q == IDLE) & out_free;
    assign accept   = in_valid & in_ready;

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             use_arith;
    logic [WIDTH-1:0] logic_res;
    logic             upd_nz;
    logic             upd_cv;
    logic             res_wr;
    logic             res_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             f_n;
    logic             f_z;
    logic             f_c;
    logic             f_v;
`ifdef ALU_MUL_EN
    logic             is_mul;
`endif

    always_comb begin
        x         = in_a;
        y         = in_b;
        cin       = 1'b0;
        use_arith = 1'b0;
        logic_res = '0;
        upd_nz    = 1'b0;
        upd_cv    = 1'b0;
        res_wr    = 1'b1;
        res_err   = 1'b0;
`ifdef ALU_MUL_EN
        is_mul    = 1'b0;
`endif
        case (in_op)
            5'h00: begin logic_res = in_a & in_b;  upd_nz = 1'b1; end
            5'h01: begin logic_res = in_a ^ in_b;  upd_nz = 1'b1; end
            5'h02: begin y = ~in_b; cin = 1'b1;       use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h03: begin x = in_b; y = ~in_a; cin = 1'b1; use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h04: begin                              use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h05: begin cin = flags_q[1];            use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h06: begin y = ~in_b; cin = flags_q[1]; use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h07: begin x = in_b; y = ~in_a; cin = flags_q[1]; use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; end
            5'h08: begin logic_res = in_a & in_b;  upd_nz = 1'b1; res_wr = 1'b0; end
            5'h09: begin logic_res = in_a ^ in_b;  upd_nz = 1'b1; res_wr = 1'b0; end
            5'h0A: begin y = ~in_b; cin = 1'b1; use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; res_wr = 1'b0; end
            5'h0B: begin use_arith = 1'b1; upd_nz = 1'b1; upd_cv = 1'b1; res_wr = 1'b0; end
            5'h0C: begin logic_res = in_a | in_b;  upd_nz = 1'b1; end
            5'h0D: begin logic_res = in_b;         upd_nz = 1'b1; end
            5'h0E: begin logic_res = in_a & ~in_b; upd_nz = 1'b1; end
            5'h0F: begin logic_res = ~in_b;        upd_nz = 1'b1; end
            5'h10: begin logic_res = in_a; end
            5'h11: begin y = WIDTH'(4); use_arith = 1'b1; end
            5'h12: begin y = in_b + WIDTH'(4); use_arith = 1'b1; end
`ifdef ALU_MUL_EN
            5'h13: begin is_mul = 1'b1; end
`endif
            default: begin res_wr = 1'b0; res_err = 1'b1; end
        endcase
    end

    assign sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign alu_res = use_arith ? sum[WIDTH-1:0] : logic_res;
    assign f_n     = alu_res[WIDTH-1];
    assign f_z     = ~|alu_res;
    assign f_c     = sum[WIDTH];
    // Overflow: both addends share a sign that the result does not.
    assign f_v     = (x[WIDTH-1] == y[WIDTH-1]) & (alu_res[WIDTH-1] != x[WIDTH-1]);

    assign flags_d[3:2] = (upd_nz & in_set_flags) ? {f_n, f_z} : flags_q[3:2];
    assign flags_d[1:0] = (upd_cv & in_set_flags) ? {f_c, f_v} : flags_q[1:0];

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             mul_set_q;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mul_res;
    logic             mul_last;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Once all bits are consumed the accumulator already holds the product.
    assign mul_res  = (cnt_q == CW'(WIDTH)) ? acc_q : acc_step;
    assign mul_last = (cnt_q >= CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            out_err_q   <= 1'b0;
            flags_q     <= 4'b0000;
`ifdef ALU_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_set_q   <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (is_mul) begin
                            state_q   <= MUL_BUSY;
                            mcand_q   <= in_a;
                            mplier_q  <= in_b;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            mul_set_q <= in_set_flags;
                        end else
`endif
                        begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= alu_res;
                            out_wr_q    <= res_wr;
                            out_err_q   <= res_err;
                            flags_q     <= flags_d;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                MUL_BUSY: begin
                    if (cnt_q != CW'(WIDTH)) begin
                        acc_q    <= acc_step;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                    if (mul_last && out_free) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= mul_res;
                        out_wr_q    <= 1'b1;
                        out_err_q   <= 1'b0;
                        if (mul_set_q) begin
                            flags_q[3:2] <= {mul_res[WIDTH-1], ~|mul_res};
                        end
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_wr    = out_wr_q;
    assign out_err   = out_err_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;

endmodule
